// File: rtl/wb_core_arbiter_pkg.sv
// Shared types and defaults for the fetch/LSU Wishbone arbiter.
package wb_core_arbiter_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    localparam int unsigned DEF_MAX_OUTSTANDING = 4;
    localparam int unsigned DEF_STARVE_LIMIT    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_IF  = 2'd1,
        OWN_LSU = 2'd2
    } arb_state_e;

    // Request payload carried from a master towards the slave.
    typedef struct packed {
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [SEL_W-1:0] sel;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_core_arbiter_if.sv
// Pipelined Wishbone bundle; MASTER drives requests, SLAVE drives responses.
interface wishbone_if;
    import wb_core_arbiter_pkg::*;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [SEL_W-1:0] sel;
    logic [DAT_W-1:0] dat_w;
    logic [DAT_W-1:0] dat_r;
    logic             ack;
    logic             err;
    logic             stall;

    modport MASTER (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, err, stall
    );

    modport SLAVE (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, err, stall
    );

endinterface

// File: rtl/wb_outstanding_ctr.sv
// Up/down count of accepted-but-unanswered requests, bounded to [0, MAX_OUTSTANDING].
module wb_outstanding_ctr
    import wb_core_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             up_c, dn_c;

    assign full_o  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign empty_o = (cnt_q == '0);
    assign up_c    = inc_i & ~full_o;
    assign dn_c    = dec_i & ~empty_o;

    // Next count: clear wins, simultaneous up and down cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (up_c && !dn_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dn_c && !up_c) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_core_arbiter.sv
// 2:1 Wishbone arbiter: LSU has priority, fetch ages into priority when starved.
module wb_core_arbiter
    import wb_core_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    wishbone_if.SLAVE  if_bus,
    wishbone_if.SLAVE  lsu_bus,
    wishbone_if.MASTER s_bus,
    output logic [1:0] grant_o
);

    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] if_wait_q, if_wait_d;

    logic    own_if_c, own_lsu_c;
    logic    own_cyc_c, own_stb_c, s_stb_c;
    wb_req_t own_req_c;
    logic    starved_c, release_c, accept_c, resp_c, fwd_c;
    logic    full_c, empty_c;

    assign own_if_c  = (state_q == OWN_IF);
    assign own_lsu_c = (state_q == OWN_LSU);
    assign starved_c = (if_wait_q == WAIT_W'(STARVE_LIMIT));
    assign release_c = (own_if_c & ~if_bus.cyc) | (own_lsu_c & ~lsu_bus.cyc);

    // Arbitration from IDLE and hand-off on owner release; no preemption.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lsu_bus.cyc && if_bus.cyc) begin
                    state_d = starved_c ? OWN_IF : OWN_LSU;
                end else if (lsu_bus.cyc) begin
                    state_d = OWN_LSU;
                end else if (if_bus.cyc) begin
                    state_d = OWN_IF;
                end
            end
            OWN_IF: begin
                if (!if_bus.cyc) begin
                    state_d = lsu_bus.cyc ? OWN_LSU : IDLE;
                end
            end
            OWN_LSU: begin
                if (!lsu_bus.cyc) begin
                    state_d = if_bus.cyc ? OWN_IF : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch aging: counts denied cycles, saturates, clears while fetch owns.
    always_comb begin
        if_wait_d = if_wait_q;
        if (own_if_c) begin
            if_wait_d = '0;
        end else if (if_bus.cyc && !starved_c) begin
            if_wait_d = if_wait_q + WAIT_W'(1);
        end
    end

    // State and aging registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            if_wait_q <= '0;
        end else begin
            state_q   <= state_d;
            if_wait_q <= if_wait_d;
        end
    end

    // Select the owning master's request; all zero when nobody owns the bus.
    always_comb begin
        own_cyc_c = 1'b0;
        own_stb_c = 1'b0;
        own_req_c = '0;
        if (own_if_c) begin
            own_cyc_c = if_bus.cyc;
            own_stb_c = if_bus.stb;
            own_req_c = '{we: if_bus.we, adr: if_bus.adr, sel: if_bus.sel, dat: if_bus.dat_w};
        end else if (own_lsu_c) begin
            own_cyc_c = lsu_bus.cyc;
            own_stb_c = lsu_bus.stb;
            own_req_c = '{we: lsu_bus.we, adr: lsu_bus.adr, sel: lsu_bus.sel, dat: lsu_bus.dat_w};
        end
    end

    // Responses only count while the owner is still in its cycle and has
    // something outstanding; late acks after an abort fall on the floor.
    assign s_stb_c  = own_stb_c & ~full_c;
    assign accept_c = own_cyc_c & s_stb_c & ~s_bus.stall;
    assign fwd_c    = own_cyc_c & ~empty_c;
    assign resp_c   = fwd_c & (s_bus.ack | s_bus.err);

    wb_outstanding_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_ctr (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clr_i   (release_c),
        .inc_i   (accept_c),
        .dec_i   (resp_c),
        .full_o  (full_c),
        .empty_o (empty_c)
    );

    assign s_bus.cyc   = own_cyc_c;
    assign s_bus.stb   = s_stb_c;
    assign s_bus.we    = own_req_c.we;
    assign s_bus.adr   = own_req_c.adr;
    assign s_bus.sel   = own_req_c.sel;
    assign s_bus.dat_w = own_req_c.dat;

    assign if_bus.ack   = own_if_c & fwd_c & s_bus.ack;
    assign if_bus.err   = own_if_c & fwd_c & s_bus.err;
    assign if_bus.stall = own_if_c ? (s_bus.stall | full_c) : 1'b1;
    assign if_bus.dat_r = own_if_c ? s_bus.dat_r : '0;

    assign lsu_bus.ack   = own_lsu_c & fwd_c & s_bus.ack;
    assign lsu_bus.err   = own_lsu_c & fwd_c & s_bus.err;
    assign lsu_bus.stall = own_lsu_c ? (s_bus.stall | full_c) : 1'b1;
    assign lsu_bus.dat_r = own_lsu_c ? s_bus.dat_r : '0;

    assign grant_o = {own_lsu_c, own_if_c};

endmodule
